// File: rtl/register_bank_module_pkg.sv
// register_bank_module_pkg: shared word type for the register bank and its write ports
package register_bank_module_pkg;
  localparam int BW = 16;
  typedef logic [BW-1:0] word_t;
endpackage

// File: rtl/register_write_port.sv
// register_write_port: decodes one write port's selector and address into a valid flag and the chosen slot data
//   destinations : concatenated functional-unit results, slot k at [k*BW +: BW]
//   selector     : 0 = idle, k = slot k-1
//   address      : target register
//   valid        : port writes on this edge
//   data         : selected slot value
module register_write_port
  import register_bank_module_pkg::*;
#(
  parameter int count = 4,
  parameter int registers = 8,
  parameter int zero_register = 1,
  localparam int SW = $clog2(count + 1),
  localparam int AW = $clog2(registers)
) (
  input  logic [count*BW-1:0] destinations,
  input  logic [SW-1:0]       selector,
  input  logic [AW-1:0]       address,
  output logic                valid,
  output word_t               data
);
  assign valid = selector != '0 && selector <= SW'(count) &&
                 {1'b0, address} < (AW+1)'(registers) &&
                 !(zero_register != 0 && address == '0);
  always_comb begin
    data = '0;
    for (int k = 0; k < count; k++)
      if (selector == SW'(k + 1)) data = destinations[k*BW +: BW];
  end
endmodule

// File: rtl/register_bank_module.sv
// register_bank_module: two-port register bank driving the functional-unit source bus, with dirty and collision tracking
//   clock, reset_n     : rising-edge clock, async active-low reset
//   destinations       : concatenated functional-unit results
//   write_selector0/1  : per-port source slot (0 = no write)
//   write_address0/1   : per-port target register
//   clear_dirty        : clears all dirty bits (same-cycle writes still mark)
//   clear_collision    : clears the sticky collision flag (same-cycle collision wins)
//   sources            : bank contents, register r at [r*BW +: BW]
//   dirty              : per-register written-since-clear bits
//   collision          : both ports hit the same register in one cycle
module register_bank_module
  import register_bank_module_pkg::*;
#(
  parameter int count = 4,
  parameter int registers = 8,
  parameter int zero_register = 1,
  localparam int SW = $clog2(count + 1),
  localparam int AW = $clog2(registers)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [count*BW-1:0]     destinations,
  input  logic [SW-1:0]           write_selector0,
  input  logic [AW-1:0]           write_address0,
  input  logic [SW-1:0]           write_selector1,
  input  logic [AW-1:0]           write_address1,
  input  logic                    clear_dirty,
  input  logic                    clear_collision,
  output logic [registers*BW-1:0] sources,
  output logic [registers-1:0]    dirty,
  output logic                    collision
);
  logic  valid0, valid1;
  word_t data0, data1;
  word_t [registers-1:0] bank_q, bank_d;
  logic [registers-1:0] dirty_q, dirty_d;
  logic collision_q, collision_d;
  register_write_port #(.count(count), .registers(registers), .zero_register(zero_register)) u_port0 (
    .destinations(destinations),
    .selector(write_selector0),
    .address(write_address0),
    .valid(valid0),
    .data(data0)
  );
  register_write_port #(.count(count), .registers(registers), .zero_register(zero_register)) u_port1 (
    .destinations(destinations),
    .selector(write_selector1),
    .address(write_address1),
    .valid(valid1),
    .data(data1)
  );
  // port 1 is applied last so it wins a same-address collision
  always_comb begin
    bank_d = bank_q;
    dirty_d = clear_dirty ? '0 : dirty_q;
    if (valid0) begin
      bank_d[write_address0] = data0;
      dirty_d[write_address0] = 1'b1;
    end
    if (valid1) begin
      bank_d[write_address1] = data1;
      dirty_d[write_address1] = 1'b1;
    end
    collision_d = (collision_q && !clear_collision) ||
                  (valid0 && valid1 && write_address0 == write_address1);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      bank_q <= '0;
      dirty_q <= '0;
      collision_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      dirty_q <= dirty_d;
      collision_q <= collision_d;
    end
  assign sources = bank_q;
  assign dirty = dirty_q;
  assign collision = collision_q;
endmodule

// File: tb/tb_register_bank_module.sv
// tb_register_bank_module: directed vector and sequence checks of register_bank_module
module tb_register_bank_module;
  localparam int BW = 16;
  logic clock = 0, reset_n = 0;
  logic [4*BW-1:0] destinations = '0;
  logic [2:0] write_selector0 = 0, write_address0 = 0, write_selector1 = 0, write_address1 = 0;
  logic clear_dirty = 0, clear_collision = 0;
  logic [8*BW-1:0] sources;
  logic [7:0] dirty;
  logic collision;
  int checks = 0, errors = 0;

  register_bank_module dut (
    .clock(clock), .reset_n(reset_n), .destinations(destinations),
    .write_selector0(write_selector0), .write_address0(write_address0),
    .write_selector1(write_selector1), .write_address1(write_address1),
    .clear_dirty(clear_dirty), .clear_collision(clear_collision),
    .sources(sources), .dirty(dirty), .collision(collision)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] s0, a0, s1, a1;
    logic [63:0] dst;
    logic cd, cc;
    int r;
    logic [15:0] rv;
    logic [7:0] dv;
    logic cv;
  } vec_t;
  vec_t v[12];

  task automatic chk(input string name, input logic [8*BW-1:0] act, input logic [8*BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] reg_of(input int r);
    return sources[r*BW +: BW];
  endfunction

  task automatic idle_inputs();
    write_selector0 = 0; write_address0 = 0; write_selector1 = 0; write_address1 = 0;
    clear_dirty = 0; clear_collision = 0; destinations = '0;
  endtask

  initial begin
    //     s0 a0 s1 a1  dst{slot3,slot2,slot1,slot0}  cd cc  reg  val       dirty  col
    v[0]  = '{0, 0, 0, 0, 64'h0000_0000_0000_0000, 0, 0, 5, 16'h0000, 8'h00, 0};
    v[1]  = '{3, 5, 0, 0, 64'h0000_005A_0000_0000, 0, 0, 5, 16'h005A, 8'h20, 0};
    v[2]  = '{1, 3, 2, 3, 64'h0000_0000_0022_0011, 0, 0, 3, 16'h0022, 8'h28, 1};
    v[3]  = '{0, 0, 0, 0, 64'h0000_0000_0000_0000, 0, 1, 3, 16'h0022, 8'h28, 0};
    v[4]  = '{1, 0, 0, 0, 64'h0000_0000_0000_00FF, 0, 0, 0, 16'h0000, 8'h28, 0};
    v[5]  = '{5, 2, 0, 0, 64'h0000_0000_0000_1234, 0, 0, 2, 16'h0000, 8'h28, 0};
    v[6]  = '{5, 1, 1, 1, 64'h0000_0000_0000_0077, 0, 0, 1, 16'h0077, 8'h2A, 0};
    v[7]  = '{1, 4, 4, 4, 64'h0044_0000_0000_0001, 0, 1, 4, 16'h0044, 8'h3A, 1};
    v[8]  = '{2, 6, 0, 0, 64'h0000_0000_0066_0000, 1, 0, 6, 16'h0066, 8'h40, 1};
    v[9]  = '{0, 0, 1, 0, 64'h0000_0000_0000_00AA, 0, 1, 0, 16'h0000, 8'h40, 0};
    v[10] = '{0, 2, 0, 2, 64'h1111_2222_3333_4444, 0, 0, 2, 16'h0000, 8'h40, 0};
    v[11] = '{4, 7, 3, 6, 64'h0BEE_0CAF_0000_0000, 0, 0, 7, 16'h0BEE, 8'hC0, 0};

    // writes presented during reset are discarded
    write_selector0 = 3; write_address0 = 2; destinations = 64'h0000_0099_0000_0000;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_sources", sources, '0);
    chk("reset_dirty", {120'b0, dirty}, '0);
    chk("reset_collision", {127'b0, collision}, '0);
    @(negedge clock);
    idle_inputs();
    reset_n = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_sources", sources, '0);
    chk("idle_dirty", {120'b0, dirty}, '0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      write_selector0 = v[i].s0; write_address0 = v[i].a0;
      write_selector1 = v[i].s1; write_address1 = v[i].a1;
      destinations = v[i].dst; clear_dirty = v[i].cd; clear_collision = v[i].cc;
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_reg%0d", i, v[i].r), {112'b0, reg_of(v[i].r)}, {112'b0, v[i].rv});
      chk($sformatf("vec%0d_dirty", i), {120'b0, dirty}, {120'b0, v[i].dv});
      chk($sformatf("vec%0d_collision", i), {127'b0, collision}, {127'b0, v[i].cv});
    end
    @(negedge clock);
    idle_inputs();
    chk("bank_after_table", sources, 128'h0BEE_0CAF_005A_0044_0022_0000_0077_0000);

    // no bypass: nothing changes before the edge, value lands one edge later
    write_selector0 = 2; write_address0 = 2; destinations = 64'h0000_0000_0ABC_0000;
    #1;
    chk("latency_before_edge", {112'b0, reg_of(2)}, '0);
    @(posedge clock);
    #1;
    chk("latency_after_edge", {112'b0, reg_of(2)}, {112'b0, 16'h0ABC});
    chk("latency_dirty", {120'b0, dirty}, {120'b0, 8'hC4});

    // set collision, then async reset between edges
    @(negedge clock);
    write_selector0 = 1; write_address0 = 5; write_selector1 = 2; write_address1 = 5;
    destinations = 64'h0000_0000_0002_0001;
    @(posedge clock);
    #1;
    chk("pre_reset_collision", {127'b0, collision}, {127'b0, 1'b1});
    #2;
    reset_n = 0;
    #1;
    chk("async_reset_sources", sources, '0);
    chk("async_reset_dirty", {120'b0, dirty}, '0);
    chk("async_reset_collision", {127'b0, collision}, '0);
    @(negedge clock);
    write_selector0 = 3; write_address0 = 1; write_selector1 = 0;
    destinations = 64'h0000_0055_0000_0000;
    reset_n = 1;
    @(posedge clock);
    #1;
    chk("post_reset_write", sources, {96'b0, 16'h0055, 16'h0000});
    chk("post_reset_dirty", {120'b0, dirty}, {120'b0, 8'h02});
    chk("post_reset_collision", {127'b0, collision}, '0);
    @(negedge clock);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
